// File: rtl/mem_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant encoding,
// access-size codes and the two-way round-robin picker.
package mem_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StInst = 2'd1,
    StData = 2'd2,
    StResp = 2'd3
  } state_e;

  typedef enum logic {
    GrantInst = 1'b0,
    GrantData = 1'b1
  } grant_e;

  localparam logic [1:0] SelByte = 2'b00;
  localparam logic [1:0] SelHalf = 2'b01;
  localparam logic [1:0] SelWord = 2'b10;

  // On contention the port that did not win last time is served.
  function automatic grant_e rr_pick2(input logic   inst_req,
                                      input logic   data_req,
                                      input grant_e last);
    if (inst_req && data_req) begin
      return (last == GrantInst) ? GrantData : GrantInst;
    end else if (data_req) begin
      return GrantData;
    end else begin
      return GrantInst;
    end
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response ports and memory-bus signals of mem_arbiter.
// slave: the arbiter's view; master: the core plus memory fabric around it.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              inst_rd_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [DATA_W-1:0] inst_data_o;
  logic              inst_valid_o;

  logic              data_rd_i;
  logic              data_we_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_data_i;
  logic [1:0]        data_sel_i;
  logic [DATA_W-1:0] data_data_o;
  logic              data_valid_o;

  logic              mem_stb_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_data_o;
  logic [1:0]        mem_sel_o;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic              mem_err_o;

  modport slave (
    input  inst_rd_i, inst_addr_i,
    input  data_rd_i, data_we_i, data_addr_i, data_data_i, data_sel_i,
    input  mem_data_i, mem_ack_i,
    output inst_data_o, inst_valid_o,
    output data_data_o, data_valid_o,
    output mem_stb_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o, mem_err_o
  );

  modport master (
    output inst_rd_i, inst_addr_i,
    output data_rd_i, data_we_i, data_addr_i, data_data_i, data_sel_i,
    output mem_data_i, mem_ack_i,
    input  inst_data_o, inst_valid_o,
    input  data_data_o, data_valid_o,
    input  mem_stb_o, mem_we_o, mem_addr_o, mem_data_o, mem_sel_o, mem_err_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch and data ports, round-robin on contention.
// Define MEM_ARB_TIMEOUT_EN to abort bus cycles after TIMEOUT cycles without ack.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  state_e            state_q, state_d;
  grant_e            last_grant_q, last_grant_d;
  logic              mem_stb_q, mem_stb_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        mem_sel_q, mem_sel_d;
  logic [DATA_W-1:0] inst_data_q, inst_data_d;
  logic [DATA_W-1:0] data_data_q, data_data_d;
  logic              inst_valid_q, inst_valid_d;
  logic              data_valid_q, data_valid_d;

  logic   data_req;
  grant_e pick;

  assign data_req = bus.data_rd_i | bus.data_we_i;
  assign pick     = rr_pick2(bus.inst_rd_i, data_req, last_grant_q);

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            timeout;

  assign timeout = (cnt_q == CntW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    mem_stb_d    = mem_stb_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_sel_d    = mem_sel_q;
    inst_data_d  = inst_data_q;
    data_data_d  = data_data_q;
    inst_valid_d = 1'b0;
    data_valid_d = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.inst_rd_i || data_req) begin
          last_grant_d = pick;
          mem_stb_d    = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
          cnt_d        = '0;
`endif
          if (pick == GrantData) begin
            // A simultaneous read+write request is a store.
            mem_we_d    = bus.data_we_i;
            mem_addr_d  = bus.data_addr_i;
            mem_wdata_d = bus.data_data_i;
            mem_sel_d   = bus.data_sel_i;
            state_d     = StData;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.inst_addr_i;
            mem_wdata_d = '0;
            mem_sel_d   = SelWord;
            state_d     = StInst;
          end
        end
      end

      StInst, StData: begin
        if (bus.mem_ack_i) begin
          mem_stb_d = 1'b0;
          state_d   = StResp;
          if (state_q == StInst) begin
            inst_data_d  = bus.mem_data_i;
            inst_valid_d = 1'b1;
          end else begin
            if (!mem_we_q) begin
              data_data_d = bus.mem_data_i;
            end
            data_valid_d = 1'b1;
          end
`ifdef MEM_ARB_TIMEOUT_EN
        end else if (timeout) begin
          mem_stb_d = 1'b0;
          state_d   = StResp;
          err_d     = 1'b1;
          if (state_q == StInst) begin
            inst_data_d  = '0;
            inst_valid_d = 1'b1;
          end else begin
            data_data_d  = '0;
            data_valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end

      StResp: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantInst;
      mem_stb_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_sel_q    <= '0;
      inst_data_q  <= '0;
      data_data_q  <= '0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      mem_stb_q    <= mem_stb_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_sel_q    <= mem_sel_d;
      inst_data_q  <= inst_data_d;
      data_data_q  <= data_data_d;
      inst_valid_q <= inst_valid_d;
      data_valid_q <= data_valid_d;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.mem_err_o = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
  assign bus.mem_err_o  = 1'b0;
`endif

  assign bus.mem_stb_o    = mem_stb_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_wdata_q;
  assign bus.mem_sel_o    = mem_sel_q;
  assign bus.inst_data_o  = inst_data_q;
  assign bus.inst_valid_o = inst_valid_q;
  assign bus.data_data_o  = data_data_q;
  assign bus.data_valid_o = data_valid_q;

endmodule
